seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode seven-segment display, consuming the four BCD digit registers produced by the sequence-detector counter. It snapshots the digit values once per refresh frame, scans one digit at a time with a configurable blanking gap between digits, and decodes each nibble to active-low segments. It sits between the counter and the board pins, and is the display-side consumer of the counter's `d3..d0` bus.

---
 rtl/seg7_pkg.sv | 10 +
 rtl/hex_to_sseg.sv | 9 +
 rtl/seg7_scan_driver.sv | 66 ++++++
 tb/tb_seg7_scan_driver.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the seven-segment scan driver
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef logic [1:0] idx_t;
endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: combinational nibble to active-low gfedcba decoder
module hex_to_sseg
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed display scanner with per-frame snapshot and blanking gap
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 65536,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  logic [CW-1:0] cnt;
  idx_t idx;
  logic [3:0] s [NUM_DIGITS];
  logic [3:0] sdp;
  logic last, blank;
  logic [6:0] dec, seg;
  assign last  = cnt == CW'(DIGIT_CYCLES - 1);
  assign blank = 32'(cnt) < 32'(BLANK_CYCLES);
  hex_to_sseg u_dec (.nib(s[idx]), .seg(dec));
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic sup;
  // a digit is suppressed when it and every more significant digit are zero
  always_comb begin
    sup = idx == 2'd3 ? s[3] == 4'd0 :
          idx == 2'd2 ? (s[3] | s[2]) == 4'd0 :
          idx == 2'd1 ? (s[3] | s[2] | s[1]) == 4'd0 : 1'b0;
    seg = sup ? SEG_BLANK : dec;
  end
`else
  assign seg = dec;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      s          <= '{default: '0};
      sdp        <= '0;
      an         <= 4'hF;
      sseg       <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) idx <= idx + 1'b1;
      if (last && idx == 2'd3) begin
        s[3] <= d3;
        s[2] <= d2;
        s[1] <= d1;
        s[0] <= d0;
        sdp  <= dp_in;
      end
      frame_tick <= last && idx == 2'd3;
      an         <= blank ? 4'hF : ~(4'b0001 << idx);
      sseg       <= blank ? 8'hFF : {~sdp[idx], seg};
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: frame-position model plus directed literal checks for seg7_scan_driver
module tb_seg7_scan_driver;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * DC;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] d3 = 4'd1, d2 = 4'd2, d1 = 4'd3, d0 = 4'd4, dp_in = 4'd0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic frame_tick;
  int checks = 0, errors = 0, cyc = 0;
  // lit-segment patterns (active-high) for hex digits; inverted for the display
  logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int pos = 0;
  logic [3:0] snap [4] = '{default: 4'd0};
  logic [3:0] snap_dp = 4'd0;
  logic [3:0] exp_an = 4'hF;
  logic [7:0] exp_sseg = 8'hFF;
  logic exp_ft = 1'b0;

  seg7_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset_n(reset_n), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .dp_in(dp_in), .an(an), .sseg(sseg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] shape(int d);
    logic hide;
    hide = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    hide = d > 0;
    for (int k = d; k < 4; k++) if (snap[k] != 4'd0) hide = 1'b0;
`endif
    return hide ? 7'h7F : ~lit[snap[d]];
  endfunction

  // model: outputs follow the frame position held before each edge
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      pos = 0;
      snap = '{default: 4'd0};
      snap_dp = 4'd0;
      exp_an = 4'hF;
      exp_sseg = 8'hFF;
      exp_ft = 1'b0;
    end else begin
      if (pos % DC < BC) begin
        exp_an = 4'hF;
        exp_sseg = 8'hFF;
      end else begin
        exp_an = 4'hF;
        exp_an[pos / DC] = 1'b0;
        exp_sseg = {~snap_dp[pos / DC], shape(pos / DC)};
      end
      exp_ft = pos == FRAME - 1;
      if (exp_ft) begin
        snap = '{d0, d1, d2, d3};
        snap_dp = dp_in;
      end
      pos = (pos + 1) % FRAME;
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("model_an", {4'h0, an}, {4'h0, exp_an});
      chk("model_sseg", sseg, exp_sseg);
      chk("model_tick", {7'h0, frame_tick}, {7'h0, exp_ft});
    end
  end

  task automatic skip(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output int at);
    at = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        at = cyc;
        return;
      end
    end
    chk("tick_timeout", 8'h0, 8'h1);
  endtask

  int t1, t2, t3, t4;

  initial begin
    skip(3);
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_sseg", sseg, 8'hFF);
    reset_n = 1'b1;
    skip(3);
    chk("first_an", {4'h0, an}, 8'h0E);
    chk("first_sseg", sseg, 8'hC0);
    wait_tick(t1);
    skip(3);
    chk("scan0_an", {4'h0, an}, 8'h0E);
    chk("scan0_sseg", sseg, 8'h99);
    skip(DC);
    chk("scan1_an", {4'h0, an}, 8'h0D);
    chk("scan1_sseg", sseg, 8'hB0);
    skip(DC);
    chk("scan2_an", {4'h0, an}, 8'h0B);
    chk("scan2_sseg", sseg, 8'hA4);
    skip(DC);
    chk("scan3_an", {4'h0, an}, 8'h07);
    chk("scan3_sseg", sseg, 8'hF9);
    {d3, d2, d1, d0} = 16'h9999;
    skip(2);
    chk("tearfree_old", sseg, 8'hF9);
    wait_tick(t2);
    chk("period", 8'(t2 - t1), 8'(FRAME));
    skip(3);
    chk("nines_sseg", sseg, 8'h90);
    dp_in = 4'b0100;
    wait_tick(t3);
    skip(3 + 2 * DC);
    chk("dp_an", {4'h0, an}, 8'h0B);
    chk("dp_sseg", sseg, 8'h10);
    dp_in = 4'b0000;
    {d3, d2, d1, d0} = 16'h0007;
    wait_tick(t4);
    skip(3);
    chk("lz0_sseg", sseg, 8'hF8);
    skip(DC);
    chk("lz1_an", {4'h0, an}, 8'h0D);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    chk("lz1_sseg", sseg, 8'hFF);
`else
    chk("lz1_sseg", sseg, 8'hC0);
`endif
    skip(DC);
    chk("mid_an", {4'h0, an}, 8'h0B);
    reset_n = 1'b0;
    skip(1);
    chk("midrst_an", {4'h0, an}, 8'h0F);
    chk("midrst_tick", {7'h0, frame_tick}, 8'h00);
    reset_n = 1'b1;
    skip(3);
    chk("restart_an", {4'h0, an}, 8'h0E);
    chk("restart_sseg", sseg, 8'hC0);
    skip(FRAME + 8);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
